sokoban_stage_ctrl: RTL and testbench



---
 rtl/sokoban_pkg.sv | 76 +++++++
 rtl/sokoban_move_eval.sv | 50 +++++
 rtl/sokoban_stage_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sokoban_stage_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sokoban_pkg.sv
// Shared encodings, field layout and grid helpers for the Sokoban stage controller.
package sokoban_pkg;

  localparam int unsigned GRID    = 8;
  localparam int unsigned COORD_W = 3;
  localparam int unsigned CELL_W  = 6;
  localparam int unsigned MAP_W   = GRID * GRID;
  localparam int unsigned STATE_W = 2 * MAP_W + 2 * COORD_W;
  localparam int unsigned DIR_W   = 2;
  localparam int unsigned STAGE_W = 2;

  localparam int unsigned BOX_MSB = 133;
  localparam int unsigned AUX_MSB = 69;
  localparam int unsigned PX_MSB  = 5;
  localparam int unsigned PY_MSB  = 2;

  typedef enum logic [DIR_W-1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_CHECK = 3'd3,
    ST_WIN   = 3'd4
  } state_e;

  // Field order matches {box_map, aux_map, px, py} of the init table.
  typedef struct packed {
    logic [MAP_W-1:0]   box;
    logic [MAP_W-1:0]   aux;
    logic [COORD_W-1:0] px;
    logic [COORD_W-1:0] py;
  } game_state_t;

  typedef struct packed {
    logic               off;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } cell_t;

  function automatic logic [CELL_W-1:0] cell_idx(input cell_t c);
    return {c.y, c.x};
  endfunction

  // One step in direction d; off is sticky so a step from an off-grid cell stays off-grid.
  function automatic cell_t step_cell(input cell_t c, input dir_e d);
    cell_t r;
    r = c;
    case (d)
      DIR_UP: begin
        r.off = c.off | (c.y == 3'd0);
        r.y   = 3'(c.y - 3'd1);
      end
      DIR_DOWN: begin
        r.off = c.off | (c.y == 3'd7);
        r.y   = 3'(c.y + 3'd1);
      end
      DIR_LEFT: begin
        r.off = c.off | (c.x == 3'd0);
        r.x   = 3'(c.x - 3'd1);
      end
      DIR_RIGHT: begin
        r.off = c.off | (c.x == 3'd7);
        r.x   = 3'(c.x + 3'd1);
      end
      default: r = c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sokoban_move_eval.sv
// Combinational evaluation of one player move: blocking, push and new position.
module sokoban_move_eval
  import sokoban_pkg::*;
(
  input  logic [MAP_W-1:0]   wall_i,
  input  logic [MAP_W-1:0]   box_i,
  input  logic [COORD_W-1:0] px_i,
  input  logic [COORD_W-1:0] py_i,
  input  logic [DIR_W-1:0]   dir_i,
  output logic               ok_c,
  output logic [MAP_W-1:0]   new_box_c,
  output logic [COORD_W-1:0] new_px_c,
  output logic [COORD_W-1:0] new_py_c
);

  cell_t             here;
  cell_t             tgt;
  cell_t             bey;
  logic [CELL_W-1:0] t_idx;
  logic [CELL_W-1:0] b_idx;
  logic              box_t;
  logic              blocked;

  assign here  = '{off: 1'b0, x: px_i, y: py_i};
  assign tgt   = step_cell(here, dir_e'(dir_i));
  assign bey   = step_cell(tgt, dir_e'(dir_i));
  assign t_idx = cell_idx(tgt);
  assign b_idx = cell_idx(bey);
  assign box_t = box_i[t_idx];

  // Off-grid flags mask the wrapped indices, so stale bits at those indices never matter.
  assign blocked = tgt.off | wall_i[t_idx] |
                   (box_t & (bey.off | wall_i[b_idx] | box_i[b_idx]));

  always_comb begin
    ok_c      = ~blocked;
    new_box_c = box_i;
    new_px_c  = px_i;
    new_py_c  = py_i;
    if (!blocked) begin
      new_px_c = tgt.x;
      new_py_c = tgt.y;
      if (box_t) begin
        new_box_c[t_idx] = 1'b0;
        new_box_c[b_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sokoban_stage_ctrl.sv
// Stage sequencer and move engine: loads a level from the init table, applies moves, detects wins.
module sokoban_stage_ctrl
  import sokoban_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned CNT_W      = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 restart,
  input  logic                 next_stage,
  input  logic                 mv_valid,
  input  logic [DIR_W-1:0]     mv_dir,
  output logic                 mv_ready,
  output logic                 mv_done,
  output logic                 mv_ok,
  output logic [STAGE_W-1:0]   stage,
  input  logic [MAP_W-1:0]     init_wall,
  input  logic [MAP_W-1:0]     init_dest,
  input  logic [STATE_W-1:0]   init_state,
  output logic [MAP_W-1:0]     wall,
  output logic [MAP_W-1:0]     destination,
  output logic [STATE_W-1:0]   game_state,
  output logic                 won,
  output logic [CNT_W-1:0]     move_cnt,
  output logic                 busy
);

  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

  state_e               state_q, state_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic [MAP_W-1:0]     wall_q, wall_d;
  logic [MAP_W-1:0]     dest_q, dest_d;
  game_state_t          gs_q, gs_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  dir_e                 dir_q, dir_d;
  logic                 done_q, done_d;
  logic                 ok_q, ok_d;
  logic                 ready_q, ready_d;
  logic                 won_q, won_d;
  logic                 busy_q, busy_d;

  logic                 ev_ok;
  logic [MAP_W-1:0]     ev_box;
  logic [COORD_W-1:0]   ev_px;
  logic [COORD_W-1:0]   ev_py;

  sokoban_move_eval u_move_eval (
    .wall_i    (wall_q),
    .box_i     (gs_q.box),
    .px_i      (gs_q.px),
    .py_i      (gs_q.py),
    .dir_i     (dir_q),
    .ok_c      (ev_ok),
    .new_box_c (ev_box),
    .new_px_c  (ev_px),
    .new_py_c  (ev_py)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      stage_q <= '0;
      wall_q  <= '0;
      dest_q  <= '0;
      gs_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_UP;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      ready_q <= 1'b0;
      won_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      wall_q  <= wall_d;
      dest_q  <= dest_d;
      gs_q    <= gs_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      ready_q <= ready_d;
      won_q   <= won_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, datapath updates and registered status flags.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    wall_d  = wall_q;
    dest_d  = dest_q;
    gs_d    = gs_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    ok_d    = 1'b0;

    case (state_q)
      ST_LOAD: begin
        wall_d  = init_wall;
        dest_d  = init_dest;
        gs_d    = game_state_t'(init_state);
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (mv_valid) begin
          dir_d   = dir_e'(mv_dir);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        done_d  = 1'b1;
        ok_d    = ev_ok;
        if (ev_ok) begin
          gs_d.box = ev_box;
          gs_d.px  = ev_px;
          gs_d.py  = ev_py;
          cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : CNT_W'(cnt_q + CNT_W'(1));
        end
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        state_d = ((gs_q.box & dest_q) == dest_q) ? ST_WIN : ST_IDLE;
      end
      ST_WIN: begin
        if (next_stage) begin
          stage_d = (stage_q == LAST_STAGE) ? '0 : STAGE_W'(stage_q + STAGE_W'(1));
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase

    // Restart overrides everything and discards any move still in EXEC.
    if (restart) begin
      state_d = ST_LOAD;
      stage_d = stage_q;
      done_d  = 1'b0;
      ok_d    = 1'b0;
      if (state_q == ST_EXEC) begin
        gs_d  = gs_q;
        cnt_d = cnt_q;
      end
    end

    ready_d = (state_d == ST_IDLE);
    won_d   = (state_d == ST_WIN);
    busy_d  = (state_d == ST_LOAD) || (state_d == ST_EXEC) || (state_d == ST_CHECK);
  end

  assign mv_ready    = ready_q;
  assign mv_done     = done_q;
  assign mv_ok       = ok_q;
  assign stage       = stage_q;
  assign wall        = wall_q;
  assign destination = dest_q;
  assign game_state  = gs_q;
  assign won         = won_q;
  assign move_cnt    = cnt_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sokoban_stage_ctrl.sv
// Directed bench for sokoban_stage_ctrl with a two-stage init table and scripted play.
module tb_sokoban_stage_ctrl;

  localparam logic [63:0] WALL0 = 64'h3828_2fe1_87f4_141c;
  localparam logic [63:0] DEST0 = 64'h0010_0002_4000_0800;
  localparam logic [63:0] BOX0  = 64'h0000_1004_2008_0000;
  localparam logic [63:0] AUX0  = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] WALL1 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] DEST1 = 64'h0000_0000_0100_0001;
  localparam logic [63:0] BOX1  = 64'h0000_0000_0001_0C01;
  localparam logic [63:0] BOX1W = 64'h0000_0000_0100_0C01;
  localparam logic [63:0] AUX1  = 64'h0F0F_0F0F_F0F0_F0F0;
  // Stage 0 after the first push down: box (4,5) -> (4,6).
  localparam logic [63:0] BOX0P = 64'h0010_0004_2008_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         restart;
  logic         next_stage;
  logic         mv_valid;
  logic [1:0]   mv_dir;
  logic         mv_ready;
  logic         mv_done;
  logic         mv_ok;
  logic [1:0]   stage;
  logic [63:0]  init_wall;
  logic [63:0]  init_dest;
  logic [133:0] init_state;
  logic [63:0]  wall;
  logic [63:0]  destination;
  logic [133:0] game_state;
  logic         won;
  logic [9:0]   move_cnt;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [133:0] gs(input logic [63:0] box, input logic [63:0] aux,
                                      input logic [2:0] px, input logic [2:0] py);
    return {box, aux, px, py};
  endfunction

  // Init table, combinational from stage.
  always_comb begin
    init_wall  = '0;
    init_dest  = '0;
    init_state = '0;
    case (stage)
      2'd0: begin
        init_wall  = WALL0;
        init_dest  = DEST0;
        init_state = gs(BOX0, AUX0, 3'd4, 3'd4);
      end
      2'd1: begin
        init_wall  = WALL1;
        init_dest  = DEST1;
        init_state = gs(BOX1, AUX1, 3'd1, 3'd0);
      end
      default: ;
    endcase
  end

  sokoban_stage_ctrl #(.NUM_STAGES(2), .CNT_W(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .restart     (restart),
    .next_stage  (next_stage),
    .mv_valid    (mv_valid),
    .mv_dir      (mv_dir),
    .mv_ready    (mv_ready),
    .mv_done     (mv_done),
    .mv_ok       (mv_ok),
    .stage       (stage),
    .init_wall   (init_wall),
    .init_dest   (init_dest),
    .init_state  (init_state),
    .wall        (wall),
    .destination (destination),
    .game_state  (game_state),
    .won         (won),
    .move_cnt    (move_cnt),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [133:0] got, input logic [133:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one move and check the done/ok pulse; returns in the cycle after CHECK.
  task automatic do_move(input logic [1:0] dir, input logic exp_ok);
    int w;
    w = 0;
    while (!mv_ready && w < 20) begin
      tick();
      w++;
    end
    check("ready_before_move", mv_ready, 1'b1);
    mv_valid = 1'b1;
    mv_dir   = dir;
    tick();
    mv_valid = 1'b0;
    tick();
    check("mv_done", mv_done, 1'b1);
    check("mv_ok", mv_ok, exp_ok);
    check("won_in_check", won, 1'b0);
    tick();
  endtask

  // Stage 0 solution: D U L L (L blocked) R U U D R R.
  logic [1:0] s0_dir [11] = '{2'd1, 2'd0, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd3, 2'd3};
  logic       s0_ok  [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  // Stage 1: L(b off-grid) D R(box at b) L L(t off-grid) D(push, win).
  logic [1:0] s1_dir [6]  = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd2, 2'd1};
  logic       s1_ok  [6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    restart    = 1'b0;
    next_stage = 1'b0;
    mv_valid   = 1'b0;
    mv_dir     = 2'd0;
    tick();
    tick();
    check("rst_stage", stage, 2'd0);
    check("rst_wall", wall, 64'h0);
    check("rst_dest", destination, 64'h0);
    check("rst_gs", game_state, 134'h0);
    check("rst_cnt", move_cnt, 10'd0);
    check("rst_ready", mv_ready, 1'b0);
    check("rst_done", mv_done, 1'b0);
    check("rst_ok", mv_ok, 1'b0);
    check("rst_won", won, 1'b0);
    check("rst_busy", busy, 1'b1);

    rst_n = 1'b1;
    tick();
    check("load0_wall", wall, WALL0);
    check("load0_dest", destination, DEST0);
    check("load0_gs", game_state, gs(BOX0, AUX0, 3'd4, 3'd4));
    check("load0_cnt", move_cnt, 10'd0);
    check("load0_ready", mv_ready, 1'b1);
    check("load0_busy", busy, 1'b0);

    next_stage = 1'b1;
    tick();
    next_stage = 1'b0;
    check("next_in_idle_stage", stage, 2'd0);
    check("next_in_idle_ready", mv_ready, 1'b1);

    do_move(2'd3, 1'b0);
    check("blocked_gs", game_state, gs(BOX0, AUX0, 3'd4, 3'd4));
    check("blocked_cnt", move_cnt, 10'd0);

    do_move(2'd1, 1'b1);
    check("push_gs", game_state, gs(BOX0P, AUX0, 3'd4, 3'd5));
    check("push_cnt", move_cnt, 10'd1);
    do_move(2'd0, 1'b1);
    check("plain_gs", game_state, gs(BOX0P, AUX0, 3'd4, 3'd4));
    check("plain_cnt", move_cnt, 10'd2);

    // Restart while the move sits in EXEC.
    mv_valid = 1'b1;
    mv_dir   = 2'd2;
    tick();
    mv_valid = 1'b0;
    restart  = 1'b1;
    check("exec_busy", busy, 1'b1);
    tick();
    restart = 1'b0;
    check("rst_exec_no_done", mv_done, 1'b0);
    check("rst_exec_gs_hold", game_state, gs(BOX0P, AUX0, 3'd4, 3'd4));
    check("rst_exec_cnt_hold", move_cnt, 10'd2);
    tick();
    check("reload_gs", game_state, gs(BOX0, AUX0, 3'd4, 3'd4));
    check("reload_cnt", move_cnt, 10'd0);
    check("reload_ready", mv_ready, 1'b1);

    for (int i = 0; i < 11; i++) do_move(s0_dir[i], s0_ok[i]);
    check("win0_won", won, 1'b1);
    check("win0_ready", mv_ready, 1'b0);
    check("win0_busy", busy, 1'b0);
    check("win0_cnt", move_cnt, 10'd10);
    check("win0_gs", game_state, gs(DEST0, AUX0, 3'd5, 3'd3));

    // Restart and next_stage together: restart wins.
    restart    = 1'b1;
    next_stage = 1'b1;
    tick();
    restart    = 1'b0;
    next_stage = 1'b0;
    check("rn_stage", stage, 2'd0);
    check("rn_busy", busy, 1'b1);
    tick();
    check("rn_gs", game_state, gs(BOX0, AUX0, 3'd4, 3'd4));
    check("rn_won", won, 1'b0);

    for (int i = 0; i < 11; i++) do_move(s0_dir[i], s0_ok[i]);
    check("win0b_won", won, 1'b1);
    next_stage = 1'b1;
    tick();
    next_stage = 1'b0;
    check("adv_stage", stage, 2'd1);
    tick();
    check("load1_wall", wall, WALL1);
    check("load1_dest", destination, DEST1);
    check("load1_gs", game_state, gs(BOX1, AUX1, 3'd1, 3'd0));
    check("load1_cnt", move_cnt, 10'd0);
    check("load1_ready", mv_ready, 1'b1);

    for (int i = 0; i < 6; i++) do_move(s1_dir[i], s1_ok[i]);
    check("win1_won", won, 1'b1);
    check("win1_cnt", move_cnt, 10'd3);
    check("win1_gs", game_state, gs(BOX1W, AUX1, 3'd0, 3'd2));

    next_stage = 1'b1;
    tick();
    next_stage = 1'b0;
    check("wrap_stage", stage, 2'd0);
    tick();
    check("wrap_wall", wall, WALL0);
    check("wrap_gs", game_state, gs(BOX0, AUX0, 3'd4, 3'd4));

    // Counter saturation: 1025 successful up/down moves.
    for (int i = 0; i < 1025; i++) do_move((i % 2 == 0) ? 2'd0 : 2'd1, 1'b1);
    check("sat_cnt", move_cnt, 10'h3FF);
    check("sat_gs", game_state, gs(BOX0, AUX0, 3'd4, 3'd3));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
